// File: rtl/booth_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_mac_pkg
// Description : Shared FSM state encoding and default widths for the
//               booth MAC sequencer and its operand FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_mac_pkg;

    localparam int c_W     = 8;   // operand width, matches multiplier A/B
    localparam int c_ACC_W = 24;  // accumulator width, at least 2*c_W
    localparam int c_CNT_W = 8;   // product counter width
    localparam int c_DEPTH = 4;   // operand FIFO depth, power of two

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_mac_sequencer_operand_fifo.sv
`default_nettype none
// ============================================================================
// Module      : operand_fifo
// Description : DEPTH x WIDTH synchronous FIFO holding {last, a, b} entries.
//               Head entry is presented combinationally on pop_data.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fifo
    import booth_mac_pkg::*;
#(
    parameter int WIDTH = 2 * c_W + 1,
    parameter int DEPTH = c_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered occupancy, so a pop never frees
    // room for a push in the same cycle.
    assign full     = (r_count == (c_AW + 1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr];

    // Storage array: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/booth_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : booth_mac_sequencer
// Description : Feeds buffered operand pairs to a serial multiplier one at a
//               time, accumulates the products and emits the group sum,
//               product count and sticky overflow when a "last" pair is done.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mac_sequencer
    import booth_mac_pkg::*;
#(
    parameter int W     = c_W,
    parameter int ACC_W = c_ACC_W,
    parameter int CNT_W = c_CNT_W,
    parameter int DEPTH = c_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_last,
    output logic             mult_start,
    output logic [W-1:0]     mult_a,
    output logic [W-1:0]     mult_b,
    input  logic [2*W-1:0]   mult_product,
    input  logic             mult_ready,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_sum,
    output logic [CNT_W-1:0] acc_count,
    output logic             acc_ovf
);
    localparam int c_ENTRY_W = 2 * W + 1;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_ENTRY_W-1:0] w_head;
    logic               w_head_last;
    logic [W-1:0]       w_head_a;
    logic [W-1:0]       w_head_b;
    logic               w_load;
    logic               w_start;
    logic               w_accumulate;
    logic               w_clear;
    logic               w_valid;
    logic               r_last;
    logic [W-1:0]       r_mult_a;
    logic [W-1:0]       r_mult_b;
    logic [ACC_W-1:0]   r_acc_sum;
    logic [CNT_W-1:0]   r_acc_count;
    logic               r_acc_ovf;
    logic [ACC_W:0]     w_sum_ext;

    assign in_ready   = !w_fifo_full;
    assign w_push     = in_valid && !w_fifo_full;
    assign {w_head_last, w_head_a, w_head_b} = w_head;

    assign mult_start = w_start;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign acc_valid  = w_valid;
    assign acc_sum    = r_acc_sum;
    assign acc_count  = r_acc_count;
    assign acc_ovf    = r_acc_ovf;

    // One extra bit on top of the accumulator captures the carry-out.
    assign w_sum_ext  = {1'b0, r_acc_sum} + (ACC_W + 1)'(mult_product);

    operand_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_operand_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({in_last, in_a, in_b}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode. GUARD exists because the multiplier
    // still shows its previous ready for one cycle after start.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        w_start      = 1'b0;
        w_accumulate = 1'b0;
        w_clear      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_load       = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_pop        = 1'b1;
                w_start      = 1'b1;
                w_next_state = ST_GUARD;
            end
            ST_GUARD: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_ready) begin
                    w_accumulate = 1'b1;
                    w_next_state = r_last ? ST_EMIT : ST_IDLE;
                end
            end
            ST_EMIT: begin
                w_valid = 1'b1;
                if (acc_ready) begin
                    w_clear      = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand registers load from the FIFO head on the IDLE->ISSUE edge and
    // hold their values between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult_a <= '0;
            r_mult_b <= '0;
            r_last   <= 1'b0;
        end else if (w_load) begin
            r_mult_a <= w_head_a;
            r_mult_b <= w_head_b;
            r_last   <= w_head_last;
        end
    end

    // Accumulator: wrapping sum, sticky carry flag, saturating count.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_acc_sum   <= '0;
            r_acc_count <= '0;
            r_acc_ovf   <= 1'b0;
        end else if (w_accumulate) begin
            r_acc_sum <= w_sum_ext[ACC_W-1:0];
            r_acc_ovf <= r_acc_ovf | w_sum_ext[ACC_W];
            if (!(&r_acc_count)) begin
                r_acc_count <= r_acc_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_booth_mac_sequencer
// Description : Self-checking bench: two sequencers (24-bit and 16-bit
//               accumulators) share one stimulus stream and a behavioural
//               multiplier; a queue-based reference predicts every result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        in_last = 1'b0;
    logic        acc_ready;
    logic        man_ready = 1'b0;
    logic        rand_ready = 1'b0;
    logic        rand_mode = 1'b0;
    logic [15:0] mult_product;
    logic        mult_ready;

    logic        in_ready0, mult_start0, acc_valid0, acc_ovf0;
    logic [7:0]  mult_a0, mult_b0, acc_count0;
    logic [23:0] acc_sum0;
    logic        in_ready1, mult_start1, acc_valid1, acc_ovf1;
    logic [7:0]  mult_a1, mult_b1, acc_count1;
    logic [15:0] acc_sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign acc_ready = rand_mode ? rand_ready : man_ready;

    booth_mac_sequencer #(.W(8), .ACC_W(24), .CNT_W(8), .DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mult_start(mult_start0),
        .mult_a(mult_a0), .mult_b(mult_b0), .mult_product(mult_product),
        .mult_ready(mult_ready), .acc_valid(acc_valid0), .acc_ready(acc_ready),
        .acc_sum(acc_sum0), .acc_count(acc_count0), .acc_ovf(acc_ovf0));

    booth_mac_sequencer #(.W(8), .ACC_W(16), .CNT_W(8), .DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mult_start(mult_start1),
        .mult_a(mult_a1), .mult_b(mult_b1), .mult_product(mult_product),
        .mult_ready(mult_ready), .acc_valid(acc_valid1), .acc_ready(acc_ready),
        .acc_sum(acc_sum1), .acc_count(acc_count1), .acc_ovf(acc_ovf1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural serial multiplier: stale ready for one cycle after start,
    // then busy for a random number of cycles, then ready with the product.
    logic [7:0] m_a, m_b;
    logic       m_pend;
    int         m_busy;
    int         lat_lo = 1;
    int         lat_hi = 5;
    always @(posedge clk) begin
        if (rst) begin
            mult_ready   <= 1'b1;
            mult_product <= 16'h0000;
            m_pend       <= 1'b0;
            m_busy       <= 0;
        end else if (mult_start0) begin
            m_a    <= mult_a0;
            m_b    <= mult_b0;
            m_pend <= 1'b1;
        end else if (m_pend) begin
            m_pend       <= 1'b0;
            mult_ready   <= 1'b0;
            mult_product <= 16'hDEAD;
            m_busy       <= $urandom_range(lat_lo, lat_hi);
        end else if (!mult_ready) begin
            if (m_busy <= 1) begin
                mult_ready   <= 1'b1;
                mult_product <= {8'h00, m_a} * {8'h00, m_b};
            end else begin
                m_busy <= m_busy - 1;
            end
        end
    end

    always @(negedge clk) rand_ready = ($urandom_range(0, 3) != 0);

    // Reference model: pairs in push order, group results from plain sums.
    typedef struct packed { logic [7:0] a; logic [7:0] b; } pair_t;
    typedef struct packed {
        logic [23:0] sum24; logic ovf24; logic [15:0] sum16; logic ovf16; logic [7:0] cnt;
    } res_t;
    pair_t  issue_q[$];
    res_t   res_q[$];
    longint grp_sum = 0;
    int     grp_cnt = 0;
    int     n_starts = 0;

    function automatic res_t mk_res(input longint s, input int c);
        res_t r;
        r.sum24 = s[23:0];
        r.ovf24 = (s >= 64'd16777216);
        r.sum16 = s[15:0];
        r.ovf16 = (s >= 64'd65536);
        r.cnt   = (c > 255) ? 8'd255 : c[7:0];
        return r;
    endfunction

    // Monitor samples mid-low-phase: inputs are settled, outputs stable.
    always begin
        pair_t p;
        res_t  r;
        @(negedge clk);
        #2;
        if (rst) begin
            issue_q.delete();
            res_q.delete();
            grp_sum = 0;
            grp_cnt = 0;
        end else begin
            if (in_valid && in_ready0) begin
                issue_q.push_back({in_a, in_b});
                grp_sum += longint'(in_a) * longint'(in_b);
                grp_cnt++;
                if (in_last) begin
                    res_q.push_back(mk_res(grp_sum, grp_cnt));
                    grp_sum = 0;
                    grp_cnt = 0;
                end
            end
            if (mult_start0) begin
                n_starts++;
                chk("start_while_emit", acc_valid0, 1'b0);
                if (issue_q.size() == 0) begin
                    chk("start_without_pair", 32'd1, 32'd0);
                end else begin
                    p = issue_q.pop_front();
                    chk("start_a", mult_a0, p.a);
                    chk("start_b", mult_b0, p.b);
                    chk("start_a_acc16", mult_a1, p.a);
                    chk("start_b_acc16", mult_b1, p.b);
                end
            end
            if (acc_valid0 && acc_ready) begin
                if (res_q.size() == 0) begin
                    chk("result_without_last", 32'd1, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    chk("sb_sum24", acc_sum0, r.sum24);
                    chk("sb_ovf24", acc_ovf0, r.ovf24);
                    chk("sb_cnt24", acc_count0, r.cnt);
                    chk("sb_valid16", acc_valid1, 1'b1);
                    chk("sb_sum16", acc_sum1, r.sum16);
                    chk("sb_ovf16", acc_ovf1, r.ovf16);
                    chk("sb_cnt16", acc_count1, r.cnt);
                end
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        while (!in_ready0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int t;
        t = 0;
        while (!acc_valid0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = acc_valid0;
        if (!ok) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_result();
        @(negedge clk); man_ready = 1'b1;
        @(negedge clk); man_ready = 1'b0;
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [23:0]     e_sum;
        logic [7:0]      e_cnt;
        logic            e_ovf;
        logic [15:0]     e_sum16;
        logic            e_ovf16;
    } grp_t;

    function automatic grp_t mk_grp(input int n, input logic [31:0] a, input logic [31:0] b,
                                    input logic [23:0] s, input logic [7:0] c, input logic o,
                                    input logic [15:0] s16, input logic o16);
        grp_t g;
        g.n = n[2:0]; g.a = a; g.b = b; g.e_sum = s; g.e_cnt = c; g.e_ovf = o;
        g.e_sum16 = s16; g.e_ovf16 = o16;
        return g;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        grp_t        tbl[6];
        bit          ok;
        int          s0, k, stable_err, n;
        logic [23:0] snap_sum;
        logic [7:0]  snap_cnt;
        logic [7:0]  ha[6];
        logic [7:0]  hb[6];
        longint      hold_sum;

        // Packed a/b fields list pair 3 first, pair 0 last.
        tbl[0] = mk_grp(1, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd5},
                        24'd15, 8'd1, 1'b0, 16'd15, 1'b0);
        tbl[1] = mk_grp(4, 32'hFFFFFFFF, 32'hFFFFFFFF, 24'h03F804, 8'd4, 1'b0, 16'hF804, 1'b1);
        tbl[2] = mk_grp(2, 32'h0000FFFF, 32'h0000FFFF, 24'h01FC02, 8'd2, 1'b0, 16'hFC02, 1'b1);
        tbl[3] = mk_grp(1, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd200},
                        24'd0, 8'd1, 1'b0, 16'd0, 1'b0);
        tbl[4] = mk_grp(3, {8'd0, 8'd1, 8'd100, 8'd10}, {8'd0, 8'd1, 8'd3, 8'd20},
                        24'd501, 8'd3, 1'b0, 16'd501, 1'b0);
        tbl[5] = mk_grp(4, {8'd128, 8'd17, 8'd50, 8'd200}, {8'd2, 8'd13, 8'd50, 8'd100},
                        24'd22977, 8'd4, 1'b0, 16'd22977, 1'b0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_mult_start", mult_start0, 1'b0);
        chk("rst_mult_a", mult_a0, 8'd0);
        chk("rst_mult_b", mult_b0, 8'd0);
        chk("rst_acc_valid", acc_valid0, 1'b0);
        chk("rst_acc_sum", acc_sum0, 24'd0);
        chk("rst_acc_count", acc_count0, 8'd0);
        chk("rst_acc_ovf", acc_ovf0, 1'b0);

        // Directed groups with fixed expectations.
        for (int g = 0; g < 6; g++) begin
            s0 = n_starts;
            for (int j = 0; j < int'(tbl[g].n); j++)
                push(tbl[g].a[j], tbl[g].b[j], j == int'(tbl[g].n) - 1);
            wait_valid(ok);
            if (ok) begin
                chk($sformatf("tbl%0d_sum", g), acc_sum0, tbl[g].e_sum);
                chk($sformatf("tbl%0d_cnt", g), acc_count0, tbl[g].e_cnt);
                chk($sformatf("tbl%0d_ovf", g), acc_ovf0, tbl[g].e_ovf);
                chk($sformatf("tbl%0d_sum16", g), acc_sum1, tbl[g].e_sum16);
                chk($sformatf("tbl%0d_ovf16", g), acc_ovf1, tbl[g].e_ovf16);
                chk($sformatf("tbl%0d_starts", g), n_starts - s0, tbl[g].n);
            end
            release_result();
        end

        // Result held in EMIT while six more pairs are offered.
        push(8'd9, 8'd9, 1'b1);
        wait_valid(ok);
        snap_sum = acc_sum0; snap_cnt = acc_count0; s0 = n_starts;
        hold_sum = 0;
        for (int j = 0; j < 6; j++) begin
            ha[j] = 8'($urandom); hb[j] = 8'($urandom);
            hold_sum += longint'(ha[j]) * longint'(hb[j]);
        end
        k = 0; stable_err = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (k < 6) begin
                in_valid = 1'b1; in_a = ha[k]; in_b = hb[k]; in_last = (k == 5);
            end else begin
                in_valid = 1'b0;
            end
            if (acc_sum0 !== snap_sum || acc_count0 !== snap_cnt || acc_valid0 !== 1'b1) stable_err++;
            if (in_valid && in_ready0) k++;
        end
        chk("hold_stable", stable_err, 0);
        chk("hold_held_sum", snap_sum, 24'd81);
        chk("hold_pushes", k, 4);
        chk("hold_in_ready", in_ready0, 1'b0);
        chk("hold_no_start", n_starts - s0, 0);
        for (int c = 0; c < 300 && k < 6; c++) begin
            @(negedge clk);
            man_ready = (c == 0);
            in_valid = 1'b1; in_a = ha[k]; in_b = hb[k]; in_last = (k == 5);
            if (in_ready0) k++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; man_ready = 1'b0;
        wait_valid(ok);
        chk("hold_group_sum", acc_sum0, hold_sum[23:0]);
        chk("hold_group_cnt", acc_count0, 8'd6);
        release_result();

        // Reset while the first pair of a two-pair group is in WAIT.
        lat_lo = 6; lat_hi = 6;
        s0 = n_starts;
        push(8'd4, 8'd4, 1'b0);
        push(8'd5, 8'd5, 1'b1);
        @(negedge clk);
        chk("rstmid_one_issued", n_starts - s0, 1);
        chk("rstmid_not_valid", acc_valid0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rstmid_in_ready", in_ready0, 1'b1);
        chk("rstmid_mult_start", mult_start0, 1'b0);
        chk("rstmid_mult_a", mult_a0, 8'd0);
        chk("rstmid_mult_b", mult_b0, 8'd0);
        chk("rstmid_acc_valid", acc_valid0, 1'b0);
        chk("rstmid_acc_sum", acc_sum0, 24'd0);
        chk("rstmid_acc_count", acc_count0, 8'd0);
        chk("rstmid_acc_ovf", acc_ovf0, 1'b0);
        s0 = n_starts;
        repeat (12) @(negedge clk);
        chk("rstmid_fifo_flushed", n_starts - s0, 0);
        lat_lo = 1; lat_hi = 5;
        push(8'd2, 8'd7, 1'b1);
        wait_valid(ok);
        chk("post_rst_sum", acc_sum0, 24'd14);
        chk("post_rst_cnt", acc_count0, 8'd1);
        chk("post_rst_ovf", acc_ovf0, 1'b0);
        release_result();

        // Random groups with random downstream back-pressure.
        rand_mode = 1'b1;
        for (int g = 0; g < 25; g++) begin
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++)
                push(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                     ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), j == n - 1);
        end
        // Long group: count saturates while the sum keeps growing.
        lat_lo = 1; lat_hi = 2;
        for (int j = 0; j < 257; j++) push(8'd1, 8'd1, j == 256);
        for (int c = 0; c < 4000 && (res_q.size() != 0 || acc_valid0); c++) @(negedge clk);
        rand_mode = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain_results", res_q.size(), 0);
        chk("drain_pairs", issue_q.size(), 0);
        chk("drain_idle", acc_valid0, 1'b0);
        finish_sim();
    end

endmodule
`default_nettype wire
